valu_issue_wb_ctrl: RTL

Issue and writeback controller wrapped around the 2-stage vector ALU pipeline.
- Accepts decoded vector/scalar FP ops from decode and drives the ALU op and global enable.
- Tracks in-flight destinations with a scoreboard to block RAW/WAW hazards.
- Captures ALU results into a writeback holding register that drains to the register file under valid/ready.

---
 rtl/valu_issue_wb_ctrl_if.sv | 42 ++++
 rtl/valu_issue_wb_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/valu_issue_wb_ctrl_if.sv
// Handshake bundle between decode, the vector ALU and the register-file writeback port.
// The controller takes the slave side; the decode/ALU/regfile environment takes the master side.
interface valu_issue_wb_ctrl_if;
  logic             issue_valid;
  logic             issue_ready;
  logic [4:0]       issue_op;
  logic [4:0]       issue_src1;
  logic [4:0]       issue_src2;
  logic             issue_src1_vec;
  logic             issue_src2_vec;
  logic             issue_src1_use;
  logic             issue_src2_use;
  logic [4:0]       issue_dst;
  logic             issue_dst_vec;
  logic [4:0]       alu_op;
  logic             alu_en;
  logic [3:0][31:0] alu_vout;
  logic [31:0]      alu_rout;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_dst;
  logic             wb_dst_vec;
  logic [127:0]     wb_data;

  modport slave (
    input  issue_valid, issue_op, issue_src1, issue_src2, issue_src1_vec, issue_src2_vec,
           issue_src1_use, issue_src2_use, issue_dst, issue_dst_vec,
    output issue_ready, alu_op, alu_en,
    input  alu_vout, alu_rout,
    output wb_valid, wb_dst, wb_dst_vec, wb_data,
    input  wb_ready
  );

  modport master (
    output issue_valid, issue_op, issue_src1, issue_src2, issue_src1_vec, issue_src2_vec,
           issue_src1_use, issue_src2_use, issue_dst, issue_dst_vec,
    input  issue_ready, alu_op, alu_en,
    output alu_vout, alu_rout,
    input  wb_valid, wb_dst, wb_dst_vec, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/valu_issue_wb_ctrl.sv
// Issue/writeback controller for the vector ALU: scoreboard hazard check, tag pipe
// that tracks the ALU stages, and a writeback holding register drained under valid/ready.
module valu_issue_wb_ctrl #(
  parameter int LAT  = 2,
  parameter int NREG = 32
) (
  input logic             clk,
  input logic             rst_n,
  valu_issue_wb_ctrl_if.slave io
);

  logic [LAT:1]       vld_pipe_q, vld_pipe_d;
  logic [LAT:1][4:0]  dst_pipe_q, dst_pipe_d;
  logic [LAT:1]       vec_pipe_q, vec_pipe_d;
  logic [NREG-1:0]    pend_s_q, pend_s_d;
  logic [NREG-1:0]    pend_v_q, pend_v_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_dst_q, wb_dst_d;
  logic               wb_dst_vec_q, wb_dst_vec_d;
  logic [127:0]       wb_data_q, wb_data_d;

  logic alu_en, hazard, issue_ready, fire, wb_fire;
  logic src1_hz, src2_hz, dst_hz;

  // Hazards look only at registered scoreboard state, so a clear becomes visible next cycle.
  always_comb begin
    alu_en      = !wb_valid_q || io.wb_ready;
    src1_hz     = io.issue_src1_use &&
                  (io.issue_src1_vec ? pend_v_q[io.issue_src1] : pend_s_q[io.issue_src1]);
    src2_hz     = io.issue_src2_use &&
                  (io.issue_src2_vec ? pend_v_q[io.issue_src2] : pend_s_q[io.issue_src2]);
    dst_hz      = io.issue_dst_vec ? pend_v_q[io.issue_dst] : pend_s_q[io.issue_dst];
    hazard      = src1_hz || src2_hz || dst_hz;
    issue_ready = rst_n && alu_en && !hazard;
    fire        = io.issue_valid && issue_ready;
    wb_fire     = wb_valid_q && io.wb_ready;
  end

  always_comb begin
    vld_pipe_d   = vld_pipe_q;
    dst_pipe_d   = dst_pipe_q;
    vec_pipe_d   = vec_pipe_q;
    wb_valid_d   = wb_valid_q;
    wb_dst_d     = wb_dst_q;
    wb_dst_vec_d = wb_dst_vec_q;
    wb_data_d    = wb_data_q;
    pend_s_d     = pend_s_q;
    pend_v_d     = pend_v_q;

    if (alu_en) begin
      vld_pipe_d[1] = fire;
      dst_pipe_d[1] = io.issue_dst;
      vec_pipe_d[1] = io.issue_dst_vec;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        dst_pipe_d[i] = dst_pipe_q[i-1];
        vec_pipe_d[i] = vec_pipe_q[i-1];
      end
      wb_valid_d = vld_pipe_q[LAT];
      if (vld_pipe_q[LAT]) begin
        wb_dst_d     = dst_pipe_q[LAT];
        wb_dst_vec_d = vec_pipe_q[LAT];
        wb_data_d    = vec_pipe_q[LAT] ? io.alu_vout : {96'b0, io.alu_rout};
      end
    end

    // Clear before set so a same-cycle set of the same bit wins.
    if (wb_fire) begin
      if (wb_dst_vec_q) pend_v_d[wb_dst_q] = 1'b0;
      else              pend_s_d[wb_dst_q] = 1'b0;
    end
    if (fire) begin
      if (io.issue_dst_vec) pend_v_d[io.issue_dst] = 1'b1;
      else                  pend_s_d[io.issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q   <= '0;
      dst_pipe_q   <= '0;
      vec_pipe_q   <= '0;
      pend_s_q     <= '0;
      pend_v_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_dst_q     <= '0;
      wb_dst_vec_q <= 1'b0;
      wb_data_q    <= '0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      dst_pipe_q   <= dst_pipe_d;
      vec_pipe_q   <= vec_pipe_d;
      pend_s_q     <= pend_s_d;
      pend_v_q     <= pend_v_d;
      wb_valid_q   <= wb_valid_d;
      wb_dst_q     <= wb_dst_d;
      wb_dst_vec_q <= wb_dst_vec_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign io.issue_ready = issue_ready;
  assign io.alu_op      = io.issue_op;
  assign io.alu_en      = alu_en;
  assign io.wb_valid    = wb_valid_q;
  assign io.wb_dst      = wb_dst_q;
  assign io.wb_dst_vec  = wb_dst_vec_q;
  assign io.wb_data     = wb_data_q;

endmodule
